bcd_clock_param: RTL and testbench

- Parametrised BCD time-of-day counter (HH:MM:SS); successor to the fixed seconds/minutes/hours clock chain.
- Built-in prescaler derives the one-second tick from the system clock, so no external enable strobe is needed.
- Adds runtime 12/24-hour display mode, a one-cycle second tick, a day-rollover pulse, and an optional alarm.
- Drives the display/segment front end directly.

---
 rtl/bcd_clock_param.sv | 226 ++++++++++++++++++++++
 tb/tb_bcd_clock_param.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_clock_param.sv
// BCD time-of-day counter (HH:MM:SS) with built-in one-second prescaler and 12/24-hour display.
// Optional alarm compiled in with `define CLOCK_ALARM_EN.
module bcd_clock_param #(
    parameter int unsigned DIV = 32'd50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       load,
    input  logic       mode12,
    input  logic [3:0] sd0,
    input  logic [2:0] sd1,
    input  logic [3:0] md0,
    input  logic [2:0] md1,
    input  logic [3:0] hd0,
    input  logic [1:0] hd1,
    output logic [3:0] sq0,
    output logic [2:0] sq1,
    output logic [3:0] mq0,
    output logic [2:0] mq1,
    output logic [3:0] hq0,
    output logic [1:0] hq1,
    output logic       pm,
    output logic       tick,
    output logic       co,
    input  logic       alm_load,
    input  logic [5:0] ahd,
    input  logic [6:0] amd,
    input  logic       alm_ack,
    output logic       alarm
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PC_LAST = PW'(DIV - 1);

    function automatic logic [3:0] clamp9(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    function automatic logic [2:0] clamp5(input logic [2:0] v);
        return (v > 3'd5) ? 3'd5 : v;
    endfunction

    // Any hours tens of 2 or more pins the hour into the 20..23 range.
    function automatic logic [5:0] clamp_hr(input logic [1:0] t, input logic [3:0] u);
        if (t >= 2'd2) begin
            return {2'd2, (u > 4'd3) ? 4'd3 : u};
        end
        return {t, clamp9(u)};
    endfunction

    logic [3:0]    s0_q, s0_d;
    logic [2:0]    s1_q, s1_d;
    logic [3:0]    m0_q, m0_d;
    logic [2:0]    m1_q, m1_d;
    logic [3:0]    h0_q, h0_d;
    logic [1:0]    h1_q, h1_d;
    logic [PW-1:0] pc_q, pc_d;
    logic          at_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_q <= '0;
            s1_q <= '0;
            m0_q <= '0;
            m1_q <= '0;
            h0_q <= '0;
            h1_q <= '0;
            pc_q <= '0;
        end else begin
            s0_q <= s0_d;
            s1_q <= s1_d;
            m0_q <= m0_d;
            m1_q <= m1_d;
            h0_q <= h0_d;
            h1_q <= h1_d;
            pc_q <= pc_d;
        end
    end

    always_comb begin
        s0_d = s0_q;
        s1_d = s1_q;
        m0_d = m0_q;
        m1_d = m1_q;
        h0_d = h0_q;
        h1_d = h1_q;
        pc_d = pc_q;

        tick   = en & (pc_q == PC_LAST) & ~clr & ~load;
        at_max = (s0_q == 4'd9) && (s1_q == 3'd5) && (m0_q == 4'd9) &&
                 (m1_q == 3'd5) && (h1_q == 2'd2) && (h0_q == 4'd3);
        co     = tick & at_max;

        if (clr) begin
            s0_d = '0;
            s1_d = '0;
            m0_d = '0;
            m1_d = '0;
            h0_d = '0;
            h1_d = '0;
            pc_d = '0;
        end else if (load) begin
            s0_d       = clamp9(sd0);
            s1_d       = clamp5(sd1);
            m0_d       = clamp9(md0);
            m1_d       = clamp5(md1);
            {h1_d, h0_d} = clamp_hr(hd1, hd0);
            pc_d       = '0;
        end else if (en) begin
            pc_d = (pc_q == PC_LAST) ? '0 : pc_q + PW'(1);
            if (tick) begin
                // Ripple carry: each digit advances only when all lower digits wrap.
                if (s0_q != 4'd9) begin
                    s0_d = s0_q + 4'd1;
                end else begin
                    s0_d = '0;
                    if (s1_q != 3'd5) begin
                        s1_d = s1_q + 3'd1;
                    end else begin
                        s1_d = '0;
                        if (m0_q != 4'd9) begin
                            m0_d = m0_q + 4'd1;
                        end else begin
                            m0_d = '0;
                            if (m1_q != 3'd5) begin
                                m1_d = m1_q + 3'd1;
                            end else begin
                                m1_d = '0;
                                if ((h1_q == 2'd2) && (h0_q == 4'd3)) begin
                                    h1_d = '0;
                                    h0_d = '0;
                                end else if (h0_q == 4'd9) begin
                                    h0_d = '0;
                                    h1_d = h1_q + 2'd1;
                                end else begin
                                    h0_d = h0_q + 4'd1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    logic [5:0] hour_bin;
    logic [5:0] disp_bin;

    always_comb begin
        hour_bin = ({4'd0, h1_q} * 6'd10) + {2'd0, h0_q};
        pm       = (hour_bin >= 6'd12);
        disp_bin = hour_bin;
        hq1      = h1_q;
        hq0      = h0_q;
        if (mode12) begin
            if (hour_bin == 6'd0) begin
                disp_bin = 6'd12;
            end else if (hour_bin > 6'd12) begin
                disp_bin = hour_bin - 6'd12;
            end
            if (disp_bin >= 6'd10) begin
                hq1 = 2'd1;
                hq0 = 4'(disp_bin - 6'd10);
            end else begin
                hq1 = 2'd0;
                hq0 = disp_bin[3:0];
            end
        end
    end

    assign sq0 = s0_q;
    assign sq1 = s1_q;
    assign mq0 = m0_q;
    assign mq1 = m1_q;

`ifdef CLOCK_ALARM_EN
    logic [1:0] ah1_q, ah1_d;
    logic [3:0] ah0_q, ah0_d;
    logic [2:0] am1_q, am1_d;
    logic [3:0] am0_q, am0_d;
    logic       alarm_q, alarm_d;
    logic       alarm_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ah1_q   <= '0;
            ah0_q   <= '0;
            am1_q   <= '0;
            am0_q   <= '0;
            alarm_q <= 1'b0;
        end else begin
            ah1_q   <= ah1_d;
            ah0_q   <= ah0_d;
            am1_q   <= am1_d;
            am0_q   <= am0_d;
            alarm_q <= alarm_d;
        end
    end

    always_comb begin
        ah1_d = ah1_q;
        ah0_d = ah0_q;
        am1_d = am1_q;
        am0_d = am0_q;
        if (alm_load) begin
            {ah1_d, ah0_d} = clamp_hr(ahd[5:4], ahd[3:0]);
            am1_d          = clamp5(amd[6:4]);
            am0_d          = clamp9(amd[3:0]);
        end
        // Only a counting tick can set the flag; load/clr suppress tick.
        alarm_set = tick && (s0_d == 4'd0) && (s1_d == 3'd0) &&
                    (m0_d == am0_q) && (m1_d == am1_q) &&
                    (h0_d == ah0_q) && (h1_d == ah1_q);
        alarm_d   = alarm_set | (alarm_q & ~alm_ack);
    end

    assign alarm = alarm_q;
`else
    logic unused_alarm_in;
    assign unused_alarm_in = &{1'b0, alm_load, ahd, amd, alm_ack};
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_clock_param.sv
// Directed bench for bcd_clock_param with DIV = 4; alarm scenario compiled with CLOCK_ALARM_EN.
module tb_bcd_clock_param;

    logic       clk = 1'b0;
    logic       rst, en, clr, load, mode12;
    logic [3:0] sd0, md0, hd0;
    logic [2:0] sd1, md1;
    logic [1:0] hd1;
    logic [3:0] sq0, mq0, hq0;
    logic [2:0] sq1, mq1;
    logic [1:0] hq1;
    logic       pm, tick, co;
    logic       alm_load, alm_ack, alarm;
    logic [5:0] ahd;
    logic [6:0] amd;

    int checks   = 0;
    int failures = 0;

    logic [19:0] tnow;
    assign tnow = {hq1, hq0, mq1, mq0, sq1, sq0};

    bcd_clock_param #(.DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .mode12(mode12),
        .sd0(sd0), .sd1(sd1), .md0(md0), .md1(md1), .hd0(hd0), .hd1(hd1),
        .sq0(sq0), .sq1(sq1), .mq0(mq0), .mq1(mq1), .hq0(hq0), .hq1(hq1),
        .pm(pm), .tick(tick), .co(co),
        .alm_load(alm_load), .ahd(ahd), .amd(amd), .alm_ack(alm_ack), .alarm(alarm)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] tval(input logic [1:0] h1, input logic [3:0] h0,
                                         input logic [2:0] m1, input logic [3:0] m0,
                                         input logic [2:0] s1, input logic [3:0] s0);
        return {h1, h0, m1, m0, s1, s0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [1:0] h1, input logic [3:0] h0,
                           input logic [2:0] m1, input logic [3:0] m0,
                           input logic [2:0] s1, input logic [3:0] s0);
        hd1 = h1; hd0 = h0; md1 = m1; md0 = m0; sd1 = s1; sd0 = s0;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; mode12 = 1'b1;
        alm_load = 1'b0; alm_ack = 1'b0; ahd = '0; amd = '0;
        sd0 = '0; sd1 = '0; md0 = '0; md1 = '0; hd0 = '0; hd1 = '0;
        step(); step();
        rst = 1'b0;
        en  = 1'b1;
        do_load(0, 5, 0, 6, 0, 7);
        step(); step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (tnow !== tval(1, 2, 0, 0, 0, 0)) begin
            failures++; $display("FAIL reset_time got=%h exp=%h", tnow, tval(1, 2, 0, 0, 0, 0));
        end
        checks++;
        if ({pm, tick, co, alarm} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags pm/tick/co/alarm got=%b exp=0000", {pm, tick, co, alarm});
        end
        step();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tick !== (i == 3)) begin
                failures++; $display("FAIL reset_first_tick cycle=%0d got=%b exp=%b", i, tick, (i == 3));
            end
            step();
        end
        checks++;
        if (tnow !== tval(1, 2, 0, 0, 0, 1)) begin
            failures++; $display("FAIL reset_first_advance got=%h exp=%h", tnow, tval(1, 2, 0, 0, 0, 1));
        end
    endtask

    task automatic test_rollover();
        mode12 = 1'b0;
        en = 1'b1;
        do_load(2, 3, 5, 9, 5, 8);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (tick !== (k % 4 == 3)) begin
                failures++; $display("FAIL roll_tick k=%0d got=%b exp=%b", k, tick, (k % 4 == 3));
            end
            checks++;
            if (co !== (k == 7)) begin
                failures++; $display("FAIL roll_co k=%0d got=%b exp=%b", k, co, (k == 7));
            end
            if (k == 4) begin
                checks++;
                if (tnow !== tval(2, 3, 5, 9, 5, 9)) begin
                    failures++; $display("FAIL roll_mid got=%h exp=%h", tnow, tval(2, 3, 5, 9, 5, 9));
                end
            end
            step();
        end
        checks++;
        if (tnow !== 20'h0) begin
            failures++; $display("FAIL roll_wrap got=%h exp=%h", tnow, 20'h0);
        end
        checks++;
        if (co !== 1'b0) begin
            failures++; $display("FAIL roll_co_after got=%b exp=0", co);
        end
    endtask

    task automatic test_clamp();
        en = 1'b0;
        mode12 = 1'b0;
        do_load(3, 7, 7, 4, 2, 12);
        checks++;
        if (tnow !== tval(2, 3, 5, 4, 2, 9)) begin
            failures++; $display("FAIL clamp_hi got=%h exp=%h", tnow, tval(2, 3, 5, 4, 2, 9));
        end
        do_load(1, 15, 3, 12, 7, 9);
        checks++;
        if (tnow !== tval(1, 9, 3, 9, 5, 9)) begin
            failures++; $display("FAIL clamp_lo got=%h exp=%h", tnow, tval(1, 9, 3, 9, 5, 9));
        end
    endtask

    task automatic test_mode12();
        en = 1'b0;
        mode12 = 1'b0;
        do_load(1, 3, 0, 5, 0, 0);
        mode12 = 1'b1; #1;
        checks++;
        if ({hq1, hq0, pm} !== {2'd0, 4'd1, 1'b1}) begin
            failures++; $display("FAIL m12_13 got=%0d%0d pm=%b exp=01 pm=1", hq1, hq0, pm);
        end
        mode12 = 1'b0; #1;
        checks++;
        if ({hq1, hq0, pm} !== {2'd1, 4'd3, 1'b1}) begin
            failures++; $display("FAIL m24_13 got=%0d%0d pm=%b exp=13 pm=1", hq1, hq0, pm);
        end
        mode12 = 1'b1;
        do_load(1, 2, 0, 0, 0, 0);
        checks++;
        if ({hq1, hq0, pm} !== {2'd1, 4'd2, 1'b1}) begin
            failures++; $display("FAIL m12_12 got=%0d%0d pm=%b exp=12 pm=1", hq1, hq0, pm);
        end
        do_load(2, 3, 0, 0, 0, 0);
        checks++;
        if ({hq1, hq0, pm} !== {2'd1, 4'd1, 1'b1}) begin
            failures++; $display("FAIL m12_23 got=%0d%0d pm=%b exp=11 pm=1", hq1, hq0, pm);
        end
        do_load(0, 9, 0, 0, 0, 0);
        checks++;
        if ({hq1, hq0, pm} !== {2'd0, 4'd9, 1'b0}) begin
            failures++; $display("FAIL m12_09 got=%0d%0d pm=%b exp=09 pm=0", hq1, hq0, pm);
        end
        mode12 = 1'b0;
        en = 1'b1;
        do_load(1, 3, 0, 5, 0, 0);
        for (int i = 0; i < 4; i++) begin
            mode12 = ~mode12;
            step();
        end
        mode12 = 1'b0; #1;
        checks++;
        if (tnow !== tval(1, 3, 0, 5, 0, 1)) begin
            failures++; $display("FAIL m12_count got=%h exp=%h", tnow, tval(1, 3, 0, 5, 0, 1));
        end
    endtask

    task automatic test_carry_freeze();
        mode12 = 1'b0;
        en = 1'b1;
        do_load(0, 9, 5, 9, 5, 9);
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (tnow !== tval(1, 0, 0, 0, 0, 0)) begin
            failures++; $display("FAIL carry_h0 got=%h exp=%h", tnow, tval(1, 0, 0, 0, 0, 0));
        end
        do_load(1, 9, 5, 9, 5, 9);
        step(); step();
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (tick !== 1'b0) begin
                failures++; $display("FAIL freeze_tick i=%0d got=%b exp=0", i, tick);
            end
            step();
        end
        checks++;
        if (tnow !== tval(1, 9, 5, 9, 5, 9)) begin
            failures++; $display("FAIL freeze_time got=%h exp=%h", tnow, tval(1, 9, 5, 9, 5, 9));
        end
        en = 1'b1;
        step();
        #1;
        checks++;
        if (tick !== 1'b1) begin
            failures++; $display("FAIL freeze_resume got=%b exp=1", tick);
        end
        step();
        checks++;
        if (tnow !== tval(2, 0, 0, 0, 0, 0)) begin
            failures++; $display("FAIL carry_h1 got=%h exp=%h", tnow, tval(2, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_back_to_back();
        mode12 = 1'b0;
        en = 1'b1;
        do_load(2, 3, 5, 9, 5, 9);
        step(); step(); step();
        checks++;
        if ({tick, co} !== 2'b11) begin
            failures++; $display("FAIL b2b_pre tick/co got=%b exp=11", {tick, co});
        end
        clr = 1'b1; load = 1'b1;
        hd1 = 1; hd0 = 0; md1 = 2; md0 = 0; sd1 = 3; sd0 = 0;
        #1;
        checks++;
        if ({tick, co} !== 2'b00) begin
            failures++; $display("FAIL b2b_suppress tick/co got=%b exp=00", {tick, co});
        end
        step();
        clr = 1'b0; load = 1'b0;
        #1;
        checks++;
        if (tnow !== 20'h0) begin
            failures++; $display("FAIL b2b_clr_wins got=%h exp=%h", tnow, 20'h0);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tick !== (i == 3)) begin
                failures++; $display("FAIL b2b_next_tick i=%0d got=%b exp=%b", i, tick, (i == 3));
            end
            step();
        end
    endtask

    task automatic test_alarm();
`ifdef CLOCK_ALARM_EN
        en = 1'b0;
        ahd = 6'h07; amd = 7'h30;
        alm_load = 1'b1;
        step();
        alm_load = 1'b0;
        do_load(0, 7, 3, 0, 0, 0);
        checks++;
        if (alarm !== 1'b0) begin
            failures++; $display("FAIL alm_load_into got=%b exp=0", alarm);
        end
        do_load(0, 7, 2, 9, 5, 9);
        en = 1'b1;
        step(); step(); step();
        checks++;
        if ({tick, alarm} !== 2'b10) begin
            failures++; $display("FAIL alm_pre tick/alarm got=%b exp=10", {tick, alarm});
        end
        step();
        checks++;
        if ({alarm, tnow} !== {1'b1, tval(0, 7, 3, 0, 0, 0)}) begin
            failures++; $display("FAIL alm_set alarm=%b t=%h exp alarm=1 t=%h", alarm, tnow, tval(0, 7, 3, 0, 0, 0));
        end
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (alarm !== 1'b1) begin
            failures++; $display("FAIL alm_sticky got=%b exp=1", alarm);
        end
        alm_ack = 1'b1;
        step();
        alm_ack = 1'b0;
        checks++;
        if (alarm !== 1'b0) begin
            failures++; $display("FAIL alm_ack got=%b exp=0", alarm);
        end
`else
        en = 1'b1;
        ahd = 6'h00; amd = 7'h01;
        alm_load = 1'b1;
        do_load(0, 0, 0, 0, 5, 9);
        alm_load = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if ({alarm, tnow} !== {1'b0, tval(0, 0, 0, 1, 0, 0)}) begin
            failures++; $display("FAIL alm_off alarm=%b t=%h exp alarm=0 t=%h", alarm, tnow, tval(0, 0, 0, 1, 0, 0));
        end
`endif
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_clamp();
        test_mode12();
        test_carry_freeze();
        test_back_to_back();
        test_alarm();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
